// File: rtl/ddc_dec_ctrl.sv
// Sequencer for the CIC -> hb1 -> hb2 decimation chain: decodes the total
// decimation, runs/stops the stages, and hides start-up transients.
module ddc_dec_ctrl #(
  parameter int CIC_MAX     = 128,
  parameter int PRIME_SAMPS = 8,
  parameter int FLUSH_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [9:0]  set_decim,
  input  logic        enable,
  input  logic        stb_chain,
  output logic [7:0]  cic_rate,
  output logic        hb1_bypass,
  output logic        hb2_bypass,
  output logic        run,
  output logic        stb_out,
  output logic        busy,
  output logic        cfg_err,
  output logic [31:0] samp_cnt
);
  localparam int PW = $clog2(PRIME_SAMPS + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [PW-1:0] PLAST = PW'(PRIME_SAMPS - 1);
  localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYC - 1);
  localparam logic [9:0]    CMAX  = 10'(CIC_MAX);

  typedef enum logic [2:0] {IDLE, CONFIG, PRIME, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [PW-1:0] prime_cnt;
  logic [FW-1:0] flush_cnt;
  logic [7:0]    pend_cic;
  logic          pend_hb1b, pend_hb2b, pend;

  // Decode: prefer using both halfbands, then hb2 only, then CIC alone.
  logic [9:0] q4, q2;
  logic [7:0] dec_cic;
  logic       dec_ok, dec_hb1b, dec_hb2b;
  always_comb begin
    q4       = {2'b00, set_decim[9:2]};
    q2       = {1'b0, set_decim[9:1]};
    dec_ok   = 1'b1;
    dec_cic  = 8'd1;
    dec_hb1b = 1'b1;
    dec_hb2b = 1'b1;
    if (set_decim[1:0] == 2'b00 && q4 >= 10'd1 && q4 <= CMAX) begin
      dec_cic  = q4[7:0];
      dec_hb1b = 1'b0;
      dec_hb2b = 1'b0;
    end else if (!set_decim[0] && q2 >= 10'd1 && q2 <= CMAX) begin
      dec_cic  = q2[7:0];
      dec_hb2b = 1'b0;
    end else if (set_decim >= 10'd1 && set_decim <= CMAX) begin
      dec_cic  = set_decim[7:0];
    end else begin
      dec_ok   = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = CONFIG;
      CONFIG:  state_n = PRIME;
      PRIME:   if (!enable || pend) state_n = DRAIN;
               else if (stb_chain && prime_cnt == PLAST) state_n = RUN;
      RUN:     if (!enable || pend) state_n = DRAIN;
      DRAIN:   if (flush_cnt == FLAST) state_n = enable ? CONFIG : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prime_cnt  <= '0;
      flush_cnt  <= '0;
      pend_cic   <= 8'd1;
      pend_hb1b  <= 1'b1;
      pend_hb2b  <= 1'b1;
      pend       <= 1'b0;
      cic_rate   <= 8'd1;
      hb1_bypass <= 1'b1;
      hb2_bypass <= 1'b1;
      run        <= 1'b0;
      stb_out    <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      samp_cnt   <= '0;
    end else begin
      state     <= state_n;
      run       <= (state_n == PRIME) || (state_n == RUN);
      busy      <= (state_n != IDLE);
      stb_out   <= (state == RUN) && stb_chain;
      flush_cnt <= (state == DRAIN) ? flush_cnt + 1'b1 : '0;
      if (state == PRIME && stb_chain) prime_cnt <= prime_cnt + 1'b1;
      if (state == RUN && stb_chain)   samp_cnt  <= samp_cnt + 32'd1;
      if (state_n == CONFIG) begin
        cic_rate   <= pend_cic;
        hb1_bypass <= pend_hb1b;
        hb2_bypass <= pend_hb2b;
        pend       <= 1'b0;
        samp_cnt   <= '0;
        prime_cnt  <= '0;
      end
      // A request landing on the apply edge wins over the pend clear.
      if (set_stb) begin
        if (dec_ok) begin
          pend_cic  <= dec_cic;
          pend_hb1b <= dec_hb1b;
          pend_hb2b <= dec_hb2b;
          pend      <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err   <= 1'b1;
        end
      end
    end
  end
endmodule
